// File: rtl/sliding_window_3x3.sv
// Raster pixel stream to registered 3x3 neighbourhood, emitted only for interior centre pixels.
// Two line buffers supply the upper rows; each window row is a three-tap shift register.

module sw_row (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [7:0]      din,
    output logic [2:0][7:0] taps
);
    // taps[0] is the leftmost column, taps[2] the newest (rightmost)
    always_ff @(posedge clk) begin
        if (rst)
            taps <= '0;
        else if (en)
            taps <= {din, taps[2:1]};
    end
endmodule

module sliding_window_3x3 #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       sof,
    input  logic [7:0] pix_in,
    output logic [7:0] sw_pixels1,
    output logic [7:0] sw_pixels2,
    output logic [7:0] sw_pixels3,
    output logic [7:0] sw_pixels4,
    output logic [7:0] sw_pixels5,
    output logic [7:0] sw_pixels6,
    output logic [7:0] sw_pixels7,
    output logic [7:0] sw_pixels8,
    output logic [7:0] sw_pixels9,
    output logic       act,
    output logic       frame_done
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] C_TWO  = CW'(2);
    localparam logic [RW-1:0] R_TWO  = RW'(2);

    logic [CW-1:0] col, cur_c;
    logic [RW-1:0] row, cur_r;
    logic [7:0]    lb0 [IMG_W];
    logic [7:0]    lb1 [IMG_W];
    logic [7:0]    a, b;
    logic          acc;
    logic [2:0][7:0]       col_in;
    logic [2:0][2:0][7:0]  win;

    assign acc = en & ~rst;

    // sof forces this pixel to (0,0) regardless of where the counters are
    always_comb begin
        cur_c = col;
        cur_r = row;
        if (sof) begin
            cur_c = '0;
            cur_r = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (cur_c == C_LAST) begin
                col <= '0;
                row <= (cur_r == R_LAST) ? '0 : cur_r + 1'b1;
            end else begin
                col <= cur_c + 1'b1;
                row <= cur_r;
            end
        end
    end

    // Read-before-write: a and b see the old contents at cur_c
    assign a = lb1[cur_c];
    assign b = lb0[cur_c];

    always_ff @(posedge clk) begin
        if (acc) begin
            lb1[cur_c] <= lb0[cur_c];
            lb0[cur_c] <= pix_in;
        end
    end

    assign col_in = {pix_in, b, a};

    genvar i;
    generate
        for (i = 0; i < 3; i++) begin : g_row
            sw_row u_row (
                .clk  (clk),
                .rst  (rst),
                .en   (en),
                .din  (col_in[i]),
                .taps (win[i])
            );
        end
    endgenerate

    assign sw_pixels1 = win[0][0];
    assign sw_pixels2 = win[0][1];
    assign sw_pixels3 = win[0][2];
    assign sw_pixels4 = win[1][0];
    assign sw_pixels5 = win[1][1];
    assign sw_pixels6 = win[1][2];
    assign sw_pixels7 = win[2][0];
    assign sw_pixels8 = win[2][1];
    assign sw_pixels9 = win[2][2];

    // Stale left columns at c<2 and unwritten line buffers at r<2 are masked here
    always_ff @(posedge clk) begin
        if (rst) begin
            act        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            act        <= en & (cur_r >= R_TWO) & (cur_c >= C_TWO);
            frame_done <= en & (cur_r == R_LAST) & (cur_c == C_LAST);
        end
    end
endmodule

// File: tb/tb_sliding_window_3x3.sv
// Bench for sliding_window_3x3: table vectors, hand sequences and random stimulus against a frame-memory model.
module tb_sliding_window_3x3;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, en4 = 1'b0, enw = 1'b0, sof = 1'b0;
    logic [7:0] pix = '0;
    logic [7:0] p4 [9];
    logic [7:0] pw [9];
    logic       act4, fd4, actw, fdw;

    sliding_window_3x3 #(.IMG_W(4), .IMG_H(4)) u4 (
        .clk(clk), .rst(rst), .en(en4), .sof(sof), .pix_in(pix),
        .sw_pixels1(p4[0]), .sw_pixels2(p4[1]), .sw_pixels3(p4[2]),
        .sw_pixels4(p4[3]), .sw_pixels5(p4[4]), .sw_pixels6(p4[5]),
        .sw_pixels7(p4[6]), .sw_pixels8(p4[7]), .sw_pixels9(p4[8]),
        .act(act4), .frame_done(fd4));

    sliding_window_3x3 #(.IMG_W(256), .IMG_H(4)) uw (
        .clk(clk), .rst(rst), .en(enw), .sof(sof), .pix_in(pix),
        .sw_pixels1(pw[0]), .sw_pixels2(pw[1]), .sw_pixels3(pw[2]),
        .sw_pixels4(pw[3]), .sw_pixels5(pw[4]), .sw_pixels6(pw[5]),
        .sw_pixels7(pw[6]), .sw_pixels8(pw[7]), .sw_pixels9(pw[8]),
        .act(actw), .frame_done(fdw));

    int checks = 0, errors = 0;
    bit sel = 0;
    int W = 4, H = 4;

    // Reference model: the current frame stored as an image, plus raster position
    logic [7:0] mem [0:3][0:255];
    int         mr = 0, mc = 0;
    logic [7:0] ew [9];
    bit         wk = 0;
    int         n_act = 0, n_fd = 0;
    logic [71:0] cur_win;
    logic [71:0] cap [$];

    typedef struct {
        logic [7:0] pix;
        bit         act;
        logic [7:0] win [9];
    } vec_t;
    vec_t tv [16];

    task automatic chk(input string nm, input logic [71:0] got, input logic [71:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp_v);
        end
    endtask

    function automatic logic [7:0] dout(input int k);
        return sel ? pw[k] : p4[k];
    endfunction

    task automatic drive(input bit e, input bit s, input logic [7:0] px, input bit r_);
        int r, c;
        bit ea, efd, ga, gf;
        rst = r_; sof = s; pix = px;
        en4 = e & ~sel; enw = e & sel;
        ea = 0; efd = 0;
        if (r_) begin
            mr = 0; mc = 0; wk = 1;
            for (int k = 0; k < 9; k++) ew[k] = '0;
        end else if (e) begin
            r = s ? 0 : mr;
            c = s ? 0 : mc;
            mem[r][c] = px;
            ea  = (r >= 2) && (c >= 2);
            efd = (r == H-1) && (c == W-1);
            wk  = ea;
            if (ea)
                for (int k = 0; k < 9; k++) ew[k] = mem[r-2+k/3][c-2+k%3];
            if (c == W-1) begin
                mc = 0;
                mr = (r == H-1) ? 0 : r + 1;
            end else begin
                mc = c + 1;
                mr = r;
            end
        end
        @(posedge clk);
        #1;
        ga = sel ? actw : act4;
        gf = sel ? fdw : fd4;
        chk("act", 72'(ga), 72'(ea));
        chk("frame_done", 72'(gf), 72'(efd));
        if (ga) n_act++;
        if (gf) n_fd++;
        cur_win = '0;
        for (int k = 0; k < 9; k++) cur_win = {cur_win[63:0], dout(k)};
        if (wk)
            for (int k = 0; k < 9; k++) chk($sformatf("win%0d", k+1), 72'(dout(k)), 72'(ew[k]));
    endtask

    // Stream one 4x4 frame from the table; optional idle cycle after each pixel
    task automatic apply_table(input int base, input bit throttle);
        cap.delete();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 8'(base + tv[i].pix), 1'b0);
            chk("tbl_act", 72'(sel ? actw : act4), 72'(tv[i].act));
            if (tv[i].act) begin
                for (int k = 0; k < 9; k++)
                    chk("tbl_win", 72'(dout(k)), 72'(base + tv[i].win[k]));
                cap.push_back(cur_win);
            end
            if (throttle) drive(1'b0, 1'b0, 8'($urandom), 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            int r, c;
            r = i / 4; c = i % 4;
            tv[i].pix = 8'(4*r + c);
            tv[i].act = (r >= 2) && (c >= 2);
            for (int k = 0; k < 9; k++)
                tv[i].win[k] = tv[i].act ? 8'(4*(r-2+k/3) + (c-2+k%3)) : 8'd0;
        end

        // Reset state
        drive(1'b0, 1'b0, 8'd0, 1'b1);
        drive(1'b0, 1'b0, 8'd0, 1'b1);
        drive(1'b0, 1'b0, 8'd0, 1'b0);

        // Basic 4x4 window
        n_act = 0; n_fd = 0;
        apply_table(0, 1'b0);
        chk("basic_acts", 72'(n_act), 72'd4);
        chk("basic_fd", 72'(n_fd), 72'd1);
        chk("first_win", cap[0], 72'h00_01_02_04_05_06_08_09_0A);
        chk("last_win", cap[3], 72'h05_06_07_09_0A_0B_0D_0E_0F);

        // Throttled input
        n_act = 0;
        apply_table(0, 1'b1);
        chk("thr_acts", 72'(n_act), 72'd4);
        chk("thr_first", cap[0], 72'h00_01_02_04_05_06_08_09_0A);

        // Back-to-back frames
        n_fd = 0;
        apply_table(0, 1'b0);
        apply_table(100, 1'b0);
        chk("b2b_fd", 72'(n_fd), 72'd2);
        chk("f2_first", cap[0], 72'h64_65_66_68_69_6A_6C_6D_6E);

        // sof resync after a 6-pixel partial frame
        n_act = 0; n_fd = 0;
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 8'(200 + i), 1'b0);
        chk("pre_sof_acts", 72'(n_act), 72'd0);
        drive(1'b1, 1'b1, 8'd0, 1'b0);
        for (int i = 1; i < 16; i++) begin
            drive(1'b1, 1'b0, tv[i].pix, 1'b0);
            if (tv[i].act)
                for (int k = 0; k < 9; k++) chk("sof_win", 72'(p4[k]), 72'(tv[i].win[k]));
        end
        chk("sof_acts", 72'(n_act), 72'd4);
        chk("sof_fd", 72'(n_fd), 72'd1);

        // Reset mid-frame with en high
        for (int i = 0; i < 11; i++) drive(1'b1, 1'b0, tv[i].pix, 1'b0);
        drive(1'b1, 1'b0, 8'hAA, 1'b1);
        chk("rst_act", 72'(act4), 72'd0);
        chk("rst_fd", 72'(fd4), 72'd0);
        chk("rst_win", cur_win, 72'd0);
        n_act = 0;
        apply_table(0, 1'b0);
        chk("rst_acts", 72'(n_act), 72'd4);
        chk("rst_last", cap[3], 72'h05_06_07_09_0A_0B_0D_0E_0F);

        // Random traffic, including sof and reset
        for (int i = 0; i < 600; i++)
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0,
                  8'($urandom), $urandom_range(0, 149) == 0);

        // Wide line wrap on the 256x4 instance
        en4 = 1'b0;
        sel = 1; W = 256; H = 4;
        drive(1'b0, 1'b0, 8'd0, 1'b1);
        n_act = 0; n_fd = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 256; c++) begin
                drive(1'b1, 1'b0, 8'(c), 1'b0);
                if (r == 2 && c == 255)
                    chk("wide_last_r2", cur_win, 72'hFD_FE_FF_FD_FE_FF_FD_FE_FF);
            end
        chk("wide_acts", 72'(n_act), 72'd508);
        chk("wide_fd", 72'(n_fd), 72'd1);
        for (int i = 0; i < 1200; i++)
            drive($urandom_range(0, 9) < 8, 1'b0, 8'($urandom), 1'b0);

        enw = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
